// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: RISC-V MEM stage with a load/store unit on a req/ack data-memory port.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses are flagged to WB instead of issued.
module mem_stage_lsu #(
  parameter int XLEN      = 32,
  parameter int CTRL_WB_W = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 valid_in,
  input  logic [CTRL_WB_W+4:0] ctrl_mem,
  input  logic [XLEN-1:0]      rd_mem,
  input  logic [XLEN-1:0]      pc4_mem,
  input  logic [XLEN-1:0]      alu_result,
  input  logic [XLEN-1:0]      write_data,
  output logic                 stall_out,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [XLEN-1:0]      dmem_addr,
  output logic [XLEN/8-1:0]    dmem_be,
  output logic [XLEN-1:0]      dmem_wdata,
  input  logic                 dmem_ack,
  input  logic [XLEN-1:0]      dmem_rdata,
  output logic                 valid_wb,
  output logic [CTRL_WB_W-1:0] ctrl_wb,
  output logic [XLEN-1:0]      rd_wb,
  output logic [XLEN-1:0]      pc4_wb,
  output logic [XLEN-1:0]      mem_data,
  output logic [XLEN-1:0]      alu_data,
  output logic                 misalign_wb
);

  // state  | meaning
  // S_IDLE | accepting; non-mem ops reach WB one cycle later
  // S_WAIT | access outstanding, dmem_* held until dmem_ack

  localparam int NB   = XLEN / 8;
  localparam int LO_W = $clog2(NB);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t r_state, w_state_nxt;

  logic                 w_memread, w_memwrite, w_mem_op, w_defined, w_trap;
  logic [2:0]           w_funct3;
  logic [CTRL_WB_W-1:0] w_wb_ctrl;
  logic [1:0]           w_size;
  logic [XLEN-1:0]      w_addr_al, w_wdata, w_lane, w_ld_ext;
  logic [NB-1:0]        w_be;
  logic [LO_W-1:0]      w_lo;

  logic [2:0]           r_funct3;
  logic                 r_ld_ok;
  logic [LO_W-1:0]      r_lo;
  logic [CTRL_WB_W-1:0] r_ctrl;
  logic [XLEN-1:0]      r_rd, r_pc4, r_alu;

  assign w_memread  = ctrl_mem[CTRL_WB_W+4];
  assign w_memwrite = ctrl_mem[CTRL_WB_W+3];
  assign w_funct3   = ctrl_mem[CTRL_WB_W+2:CTRL_WB_W];
  assign w_wb_ctrl  = ctrl_mem[CTRL_WB_W-1:0];
  assign w_mem_op   = valid_in & (w_memread | w_memwrite);

  function automatic logic [XLEN-1:0] ext(input logic [XLEN-1:0] v, input int bits,
                                          input logic sgn);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = (i < bits) ? v[i] : (sgn & v[bits-1]);
    return r;
  endfunction

  // Size code: 0 byte, 1 half, 2 word, 3 double. memread wins when both are set.
  always_comb begin
    w_size    = 2'd0;
    w_defined = 1'b0;
    if (w_memread) begin
      case (w_funct3)
        3'b000, 3'b100: begin w_size = 2'd0; w_defined = 1'b1; end
        3'b001, 3'b101: begin w_size = 2'd1; w_defined = 1'b1; end
        3'b010:         begin w_size = 2'd2; w_defined = 1'b1; end
        3'b110:         begin w_size = 2'd2; w_defined = (XLEN == 64); end
        3'b011:         begin w_size = 2'd3; w_defined = (XLEN == 64); end
        default: ;
      endcase
    end else begin
      case (w_funct3)
        3'b000:  begin w_size = 2'd0; w_defined = 1'b1; end
        3'b001:  begin w_size = 2'd1; w_defined = 1'b1; end
        3'b010:  begin w_size = 2'd2; w_defined = 1'b1; end
        3'b011:  begin w_size = 2'd3; w_defined = (XLEN == 64); end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_addr_al = alu_result;
    if (w_defined) begin
      case (w_size)
        2'd1:    w_addr_al = {alu_result[XLEN-1:1], 1'b0};
        2'd2:    w_addr_al = {alu_result[XLEN-1:2], 2'b00};
        2'd3:    w_addr_al = {alu_result[XLEN-1:3], 3'b000};
        default: w_addr_al = alu_result;
      endcase
    end
    w_lo = w_addr_al[LO_W-1:0];
  end

  always_comb begin
    w_be = '0;
    if (w_defined) begin
      case (w_size)
        2'd0:    w_be = NB'(1)  << w_lo;
        2'd1:    w_be = NB'(3)  << w_lo;
        2'd2:    w_be = NB'(15) << w_lo;
        default: w_be = '1;
      endcase
    end
    w_wdata = '0;
    if (!w_memread) begin
      case (w_size)
        2'd0:    w_wdata = {NB{write_data[7:0]}};
        2'd1:    w_wdata = {(NB/2){write_data[15:0]}};
        2'd2:    w_wdata = {(NB/4){write_data[31:0]}};
        default: w_wdata = write_data;
      endcase
    end
  end

  assign w_lane = dmem_rdata >> {r_lo, 3'b000};

  always_comb begin
    w_ld_ext = '0;
    case (r_funct3)
      3'b000:  w_ld_ext = ext(w_lane, 8, 1'b1);
      3'b100:  w_ld_ext = ext(w_lane, 8, 1'b0);
      3'b001:  w_ld_ext = ext(w_lane, 16, 1'b1);
      3'b101:  w_ld_ext = ext(w_lane, 16, 1'b0);
      3'b010:  w_ld_ext = ext(w_lane, 32, 1'b1);
      3'b110:  w_ld_ext = ext(w_lane, 32, 1'b0);
      3'b011:  w_ld_ext = w_lane;
      default: w_ld_ext = '0;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic w_misalign;
  logic r_misalign;
  // Misaligned exactly when aligning down would move the address.
  assign w_misalign  = w_defined & (w_addr_al != alu_result);
  assign w_trap      = w_mem_op & w_misalign;
  assign misalign_wb = r_misalign;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                r_misalign <= 1'b0;
    else if (r_state == S_IDLE) r_misalign <= w_trap;
    else if (dmem_ack)          r_misalign <= 1'b0;
  end
`else
  assign w_trap      = 1'b0;
  assign misalign_wb = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    stall_out   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_op && !w_trap) begin
          stall_out   = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        stall_out = ~dmem_ack;
        if (dmem_ack) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      valid_wb   <= 1'b0;
      ctrl_wb    <= '0;
      rd_wb      <= '0;
      pc4_wb     <= '0;
      mem_data   <= '0;
      alu_data   <= '0;
      r_funct3   <= '0;
      r_ld_ok    <= 1'b0;
      r_lo       <= '0;
      r_ctrl     <= '0;
      r_rd       <= '0;
      r_pc4      <= '0;
      r_alu      <= '0;
    end else if (r_state == S_IDLE) begin
      if (!valid_in) begin
        valid_wb <= 1'b0;
      end else if (w_trap) begin
        valid_wb <= 1'b1;
        ctrl_wb  <= '0;
        rd_wb    <= rd_mem;
        pc4_wb   <= pc4_mem;
        mem_data <= '0;
        alu_data <= alu_result;
      end else if (w_mem_op) begin
        valid_wb   <= 1'b0;
        dmem_req   <= 1'b1;
        dmem_we    <= ~w_memread;
        dmem_addr  <= {w_addr_al[XLEN-1:LO_W], {LO_W{1'b0}}};
        dmem_be    <= w_be;
        dmem_wdata <= w_wdata;
        r_funct3   <= w_funct3;
        r_ld_ok    <= w_memread & w_defined;
        r_lo       <= w_lo;
        r_ctrl     <= w_wb_ctrl;
        r_rd       <= rd_mem;
        r_pc4      <= pc4_mem;
        r_alu      <= alu_result;
      end else begin
        valid_wb <= 1'b1;
        ctrl_wb  <= w_wb_ctrl;
        rd_wb    <= rd_mem;
        pc4_wb   <= pc4_mem;
        mem_data <= '0;
        alu_data <= alu_result;
      end
    end else if (dmem_ack) begin
      dmem_req <= 1'b0;
      valid_wb <= 1'b1;
      ctrl_wb  <= r_ctrl;
      rd_wb    <= r_rd;
      pc4_wb   <= r_pc4;
      alu_data <= r_alu;
      mem_data <= r_ld_ok ? w_ld_ext : '0;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu (XLEN=32): directed vectors, memory responder, WB monitor.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_in;
  logic [7:0]  ctrl_mem;
  logic [31:0] rd_mem, pc4_mem, alu_result, write_data;
  logic        stall_out, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        valid_wb;
  logic [2:0]  ctrl_wb;
  logic [31:0] rd_wb, pc4_wb, mem_data, alu_data;
  logic        misalign_wb;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0]  ctrl;
    logic [31:0] rd;
    logic [31:0] pc4;
    logic [31:0] mem;
    logic [31:0] alu;
    logic        mis;
  } wb_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
  } mem_t;

  wb_t  q_wb[$];
  mem_t q_mem[$];

  mem_stage_lsu #(.XLEN(32), .CTRL_WB_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .ctrl_mem(ctrl_mem),
    .rd_mem(rd_mem), .pc4_mem(pc4_mem), .alu_result(alu_result), .write_data(write_data),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .valid_wb(valid_wb), .ctrl_wb(ctrl_wb), .rd_wb(rd_wb), .pc4_wb(pc4_wb),
    .mem_data(mem_data), .alu_data(alu_data), .misalign_wb(misalign_wb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mk(input logic rd, input logic wr, input logic [2:0] f3,
                                    input logic [2:0] wb);
    return {rd, wr, f3, wb};
  endfunction

  task automatic exp_wb(input logic [2:0] c, input logic [31:0] rd, input logic [31:0] pc4,
                        input logic [31:0] md, input logic [31:0] alu, input logic mis);
    wb_t w;
    w.ctrl = c; w.rd = rd; w.pc4 = pc4; w.mem = md; w.alu = alu; w.mis = mis;
    q_wb.push_back(w);
  endtask

  task automatic exp_mem(input logic we, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd, input int waits, input logic [31:0] rdata);
    mem_t m;
    m.we = we; m.addr = a; m.be = be; m.wdata = wd; m.waits = waits; m.rdata = rdata;
    q_mem.push_back(m);
  endtask

  // Called at posedge+1; returns at posedge+1 after the instruction is accepted.
  task automatic issue(input string name, input logic [7:0] c, input logic [31:0] rd,
                       input logic [31:0] pc4, input logic [31:0] alu, input logic [31:0] wd,
                       input int exp_stall);
    int st = 0;
    int k = 0;
    valid_in = 1'b1; ctrl_mem = c; rd_mem = rd; pc4_mem = pc4;
    alu_result = alu; write_data = wd;
    @(negedge clk); #1;
    while (stall_out && k < 200) begin
      st++; k++;
      @(negedge clk); #1;
    end
    if (k >= 200) begin
      checks++; failures++;
      $display("FAIL %s_timeout: stall_out still 1 after %0d cycles, required release", name, k);
    end
    chk({name, "_stall"}, 200'(st), 200'(exp_stall));
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  // Memory responder: checks each request against the expected queue, acks after waits.
  initial begin
    mem_t m;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (dmem_req) begin
        if (q_mem.size() == 0) begin
          checks++; failures++;
          $display("FAIL dmem_unexpected: got req addr %h, required no request", dmem_addr);
          m.waits = 0; m.rdata = '0;
        end else begin
          m = q_mem.pop_front();
          chk("dmem_req", {dmem_we, dmem_addr, dmem_be, dmem_wdata},
              {m.we, m.addr, m.be, m.wdata});
        end
        repeat (m.waits) @(negedge clk);
        dmem_ack = 1'b1;
        dmem_rdata = m.rdata;
        @(negedge clk);
        dmem_ack = 1'b0;
        dmem_rdata = '0;
      end
    end
  end

  // WB monitor
  always @(negedge clk) begin
    wb_t w;
    if (reset_n && valid_wb) begin
      if (q_wb.size() == 0) begin
        checks++; failures++;
        $display("FAIL wb_unexpected: got valid_wb alu_data %h, required none", alu_data);
      end else begin
        w = q_wb.pop_front();
        chk("wb_payload", {ctrl_wb, rd_wb, pc4_wb, mem_data, alu_data, misalign_wb}, w);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    valid_in = 1'b0; ctrl_mem = '0; rd_mem = '0; pc4_mem = '0;
    alu_result = '0; write_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {stall_out, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, valid_wb,
                          ctrl_wb, rd_wb, pc4_wb, mem_data, alu_data, misalign_wb}, '0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset while an access is outstanding
    exp_mem(1'b0, 32'h40, 4'hF, 32'h0, 8, 32'h0);
    valid_in = 1'b1; ctrl_mem = mk(1, 0, 3'b010, 3'b001); alu_result = 32'h40;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("req_before_reset", 200'(dmem_req), 200'(1));
    reset_n = 1'b0;
    #1;
    chk("reset_mid_wait", {stall_out, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, valid_wb,
                           ctrl_wb, rd_wb, pc4_wb, mem_data, alu_data, misalign_wb}, '0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (14) @(posedge clk);
    #1;

    // Non-mem op, latency 1, no stall
    exp_wb(3'b011, 32'd5, 32'h10, 32'h0, 32'h1234, 1'b0);
    issue("alu_op", mk(0, 0, 3'b000, 3'b011), 32'd5, 32'h10, 32'h1234, 32'h0, 0);
    @(posedge clk); #1;

    // SB 0x103, three wait states
    exp_mem(1'b1, 32'h100, 4'h8, 32'hABABABAB, 3, 32'h0);
    exp_wb(3'b000, 32'd0, 32'h14, 32'h0, 32'h103, 1'b0);
    issue("sb", mk(0, 1, 3'b000, 3'b000), 32'd0, 32'h14, 32'h103, 32'h000000AB, 4);

    // LB / LBU 0x102, no wait states
    exp_mem(1'b0, 32'h100, 4'h4, 32'h0, 0, 32'h00800000);
    exp_wb(3'b001, 32'd6, 32'h18, 32'hFFFFFF80, 32'h102, 1'b0);
    issue("lb", mk(1, 0, 3'b000, 3'b001), 32'd6, 32'h18, 32'h102, 32'h0, 1);
    exp_mem(1'b0, 32'h100, 4'h4, 32'h0, 0, 32'h00800000);
    exp_wb(3'b001, 32'd7, 32'h1C, 32'h00000080, 32'h102, 1'b0);
    issue("lbu", mk(1, 0, 3'b100, 3'b001), 32'd7, 32'h1C, 32'h102, 32'h0, 1);
    @(posedge clk); #1;

    // LH 0x2 then back-to-back LW 0x4
    exp_mem(1'b0, 32'h0, 4'hC, 32'h0, 0, 32'h80010000);
    exp_wb(3'b001, 32'd8, 32'h20, 32'hFFFF8001, 32'h2, 1'b0);
    exp_mem(1'b0, 32'h4, 4'hF, 32'h0, 1, 32'hDEADBEEF);
    exp_wb(3'b001, 32'd9, 32'h24, 32'hDEADBEEF, 32'h4, 1'b0);
    issue("lh", mk(1, 0, 3'b001, 3'b001), 32'd8, 32'h20, 32'h2, 32'h0, 1);
    issue("lw_b2b", mk(1, 0, 3'b010, 3'b001), 32'd9, 32'h24, 32'h4, 32'h0, 2);

    // SH / SW lane replication
    exp_mem(1'b1, 32'h104, 4'hC, 32'hABCDABCD, 0, 32'h0);
    exp_wb(3'b000, 32'd0, 32'h28, 32'h0, 32'h106, 1'b0);
    issue("sh", mk(0, 1, 3'b001, 3'b000), 32'd0, 32'h28, 32'h106, 32'h1234ABCD, 1);
    exp_mem(1'b1, 32'h108, 4'hF, 32'hCAFEF00D, 2, 32'h0);
    exp_wb(3'b000, 32'd0, 32'h2C, 32'h0, 32'h108, 1'b0);
    issue("sw", mk(0, 1, 3'b010, 3'b000), 32'd0, 32'h2C, 32'h108, 32'hCAFEF00D, 3);

    // LHU zero-extension, undefined funct3, read+write treated as load
    exp_mem(1'b0, 32'h0, 4'h3, 32'h0, 0, 32'h0000F00F);
    exp_wb(3'b001, 32'd10, 32'h30, 32'h0000F00F, 32'h0, 1'b0);
    issue("lhu", mk(1, 0, 3'b101, 3'b001), 32'd10, 32'h30, 32'h0, 32'h0, 1);
    exp_mem(1'b0, 32'h20, 4'h0, 32'h0, 1, 32'hFFFFFFFF);
    exp_wb(3'b001, 32'd11, 32'h34, 32'h0, 32'h20, 1'b0);
    issue("undef_f3", mk(1, 0, 3'b011, 3'b001), 32'd11, 32'h34, 32'h20, 32'h0, 2);
    exp_mem(1'b0, 32'h30, 4'hF, 32'h0, 0, 32'h13572468);
    exp_wb(3'b001, 32'd12, 32'h38, 32'h13572468, 32'h30, 1'b0);
    issue("rd_and_wr", mk(1, 1, 3'b010, 3'b001), 32'd12, 32'h38, 32'h30, 32'h55555555, 1);
    @(posedge clk); #1;

    // Misaligned LW 0x6
`ifdef MEM_MISALIGN_TRAP_EN
    exp_wb(3'b000, 32'd13, 32'h3C, 32'h0, 32'h6, 1'b1);
    issue("lw_misalign", mk(1, 0, 3'b010, 3'b001), 32'd13, 32'h3C, 32'h6, 32'h0, 0);
`else
    exp_mem(1'b0, 32'h4, 4'hF, 32'h0, 0, 32'h11223344);
    exp_wb(3'b001, 32'd13, 32'h3C, 32'h11223344, 32'h6, 1'b0);
    issue("lw_misalign", mk(1, 0, 3'b010, 3'b001), 32'd13, 32'h3C, 32'h6, 32'h0, 1);
`endif

    repeat (6) @(posedge clk);
    #1;
    chk("wb_queue_drained", 200'(q_wb.size()), 200'(0));
    chk("mem_queue_drained", 200'(q_mem.size()), 200'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
